binary_to_bcd: RTL

Sequential double-dabble converter that turns an unsigned binary measurement into the packed 11-digit BCD word consumed by the LED segment driver in the DPM display path. It sits directly upstream of `Segment_Driver`, and its `o_bcdData` connects straight to that block's `i_bcdData`. It optionally replaces leading zeros with the blank code 4'hF and saturates out-of-range inputs to all nines.

---
 rtl/binary_to_bcd_if.sv | 24 ++
 rtl/binary_to_bcd.sv | 132 +++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_if.sv
// Request/result channel of the binary_to_bcd converter. The requester drives
// the binary value and its valid flag. The converter returns ready, the packed
// BCD word, the result pulse and the overflow flag.
interface binary_to_bcd_if #(
  parameter int BIN_WIDTH = 37,
  parameter int DIGITS    = 11
);
  logic [BIN_WIDTH-1:0] i_binData;
  logic                 i_valid;
  logic                 o_ready;
  logic [4*DIGITS-1:0]  o_bcdData;
  logic                 o_valid;
  logic                 o_overflow;

  modport master (
    output i_binData, i_valid,
    input  o_ready, o_bcdData, o_valid, o_overflow
  );

  modport slave (
    input  i_binData, i_valid,
    output o_ready, o_bcdData, o_valid, o_overflow
  );
endinterface

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble binary to packed-BCD converter. Each conversion
// takes one bit per cycle. The result saturates to all nines when the input
// has more than DIGITS decimal digits. Leading zeros can optionally be
// replaced by the blank code 4'hF for the segment driver.
module binary_to_bcd #(
  parameter int BIN_WIDTH     = 37,
  parameter int DIGITS        = 11,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic            i_clk,
  input logic            i_reset,
  binary_to_bcd_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  // Largest value that fits in DIGITS decimal digits. It is computed wide
  // so that the comparison still holds when 10^DIGITS exceeds 2^BIN_WIDTH.
  function automatic logic [127:0] max_value();
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 128'd10;
    return p - 128'd1;
  endfunction

  localparam logic [127:0] MAX_VAL = max_value();

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;

  logic [BCD_W-1:0]     adjusted;
  logic [BCD_W-1:0]     result;
  logic                 seen_nonzero;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  // A digit is at most 9, so the corrected value fits in 4 bits.
  always_comb begin
    adjusted = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) adjusted[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  // Output formatting: saturate on overflow, otherwise blank every digit
  // above the highest nonzero one. Digit 0 always shows.
  always_comb begin
    result       = scratch_q;
    seen_nonzero = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (scratch_q[4*d +: 4] != 4'd0) seen_nonzero = 1'b1;
      if (BLANK_LEADING && !seen_nonzero) result[4*d +: 4] = 4'hF;
    end
    if (ovf_q) result = {DIGITS{4'h9}};
  end

  // Next-state and datapath logic for the IDLE -> SHIFT -> FINISH sequence.
  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          bin_d     = bus.i_binData;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_WIDTH);
          ovf_d     = ({{(128 - BIN_WIDTH){1'b0}}, bus.i_binData} > MAX_VAL);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = {adjusted, bin_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d      = result;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs, with a synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // Working registers for the conversion.
  // NOTE: these are left without reset. Each one is loaded on the accept edge
  // before it is read.
  always_ff @(posedge i_clk) begin
    bin_q     <= bin_d;
    scratch_q <= scratch_d;
    cnt_q     <= cnt_d;
    ovf_q     <= ovf_d;
  end

  assign bus.o_ready    = (state_q == IDLE) && !i_reset;
  assign bus.o_bcdData  = bcd_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_overflow = overflow_q;

endmodule
